uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Serial transmit engine for the UART peripheral: accepts one byte per LOAD strobe from the processor output port and serialises it onto TX.
- Frame format is selected by BAUD/EIGHT/PEN/OHEL, matching what the receive engine decodes on the far end of the line.
- Exposes TXRDY for the UART status byte and the interrupt OR, plus a one-cycle TX_DONE pulse.

Parameters:
- CLK_HZ, 100000000, system clock frequency; the baud divisor table is computed from it.
- DIV_OVERRIDE, 0, when nonzero, used as the bit-time divisor for every BAUD code (simulation only).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BAUD  in  4  baud rate select code.
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  in  1  parity enable.
- OHEL  in  1  parity sense: 1 = odd, 0 = even.
- OUT_PORT  in  8  byte to transmit; sampled on an accepted LOAD.
- LOAD  in  1  write strobe (the UART writes_0 decode).
- TX  out  1  serial line; idles high.
- TXRDY  out  1  1 = engine idle and able to accept LOAD.
- TX_DONE  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (RESET=0, asynchronous): TX=1, TXRDY=1, TX_DONE=0, state IDLE, all counters and the shift register cleared (shift register to all-ones).
- Divisor table, in bit-time clocks at 100 MHz: 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, 10:217, 11:109, 12-15:109.
- For other CLK_HZ values: divisor = round(CLK_HZ/rate).
- The bit counter is 19 bits wide.
- Accept rule: LOAD=1 and TXRDY=1 at edge t. LOAD while TXRDY=0 is ignored, with no side effects.
- On acceptance at edge t, the engine latches OUT_PORT, BAUD, EIGHT and PEN/OHEL. Input changes later in the frame have no effect on it.
- At t+1: TXRDY=0, state SHIFT, TX=0 (start bit).
- Frame is always 11 bit-times; bits are sent LSB first after the start bit. Unused positions are filled with 1.
  - EIGHT=1, PEN=1: start, D0-D7, P, stop.
  - EIGHT=1, PEN=0: start, D0-D7, stop, stop.
  - EIGHT=0, PEN=1: start, D0-D6, P, stop, stop.
  - EIGHT=0, PEN=0: start, D0-D6, stop, stop, stop.
- Parity bit P = XOR of the transmitted data bits (7 or 8) XOR OHEL.
- Each bit is held exactly DIV clocks; the shift happens when the bit counter reaches DIV-1, after which the counter clears. The bit index runs 0..10.
- When bit 10's bit-time ends (edge t+1+11*DIV):
  - TXRDY=1 and TX_DONE=1 for one cycle.
  - TX=1; state returns to IDLE.
  - TXRDY is therefore low for exactly 11*DIV cycles.
- Back-to-back: LOAD asserted in the same cycle TXRDY reads 1 is accepted. The next start bit begins one cycle later with no extra idle gap.
- RESET asserted mid-frame aborts immediately: TX=1 and TXRDY=1 asynchronously. No TX_DONE is issued.
- States: IDLE -> SHIFT on accepted LOAD; SHIFT -> IDLE after the last bit. There are no other states.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME_BITS=11
  - the baud divisor function (BAUD, CLK_HZ) -> divisor, used by both the tx and rx engines
  - the parity function
- Sub-module uart_baud_tick: a loadable 19-bit counter that emits a bit_done pulse every DIV clocks while enabled, and clears when disabled.

Test Plan:
- Reset: hold RESET=0, then release with no LOAD -> TX=1, TXRDY=1, TX_DONE=0 for 100 cycles.
- Format 8N (DIV_OVERRIDE=16, EIGHT=1, PEN=0), LOAD 0xA5 -> TX bits 0,1,0,1,0,0,1,0,1,1,1, each held 16 cycles. TXRDY is low exactly 176 cycles, and TX_DONE pulses once.
- Parity: EIGHT=1, PEN=1, OHEL=0, byte 0x07 -> P=1. Same with OHEL=1 -> P=0. EIGHT=0, PEN=1, OHEL=0, byte 0xFF -> D0-D6 all 1, P=1, then two stop bits.
- Ignored LOAD / config change: a second LOAD of 0x3C mid-frame, plus toggling EIGHT/PEN, leaves the frame identical to the first byte and produces no second frame.
- Back-to-back: LOAD 0x55 in the same cycle TXRDY rises -> the next start bit begins on the following cycle. Total for two frames = 352 cycles.
- Reset mid-frame: assert RESET at bit 5 -> TX=1 and TXRDY=1 immediately, no TX_DONE. After release, a new LOAD transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame size, transmit FSM states, and the baud divisor
// and parity helpers used by both the transmit and receive engines.
package uart_pkg;

    localparam int FRAME_BITS = 11;
    localparam int CNT_W      = 19;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    function automatic int unsigned baud_rate(input logic [3:0] baud);
        case (baud)
            4'd0:    return 300;
            4'd1:    return 1200;
            4'd2:    return 2400;
            4'd3:    return 4800;
            4'd4:    return 9600;
            4'd5:    return 19200;
            4'd6:    return 38400;
            4'd7:    return 57600;
            4'd8:    return 115200;
            4'd9:    return 230400;
            4'd10:   return 460800;
            default: return 921600;
        endcase
    endfunction

    // Bit time in system clocks, rounded to nearest.
    function automatic logic [CNT_W-1:0] baud_div(input logic [3:0] baud, input int unsigned clk_hz);
        longint unsigned rate;
        longint unsigned q;
        rate = 64'(baud_rate(baud));
        q    = (64'(clk_hz) + rate / 2) / rate;
        return q[CNT_W-1:0];
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input logic eight, input logic odd);
        return (eight ? ^data : ^data[6:0]) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: pulses bit_done on the last clock of every div-clock period
// while enabled, and holds at zero while disabled.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             bit_done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        bit_done = en && (cnt_q == div - CNT_W'(1));
        if (!en || bit_done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: latches a byte and its frame format on LOAD and shifts an
// 11-bit frame out on TX, LSB first, one bit per divisor period.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned DIV_OVERRIDE = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] BAUD,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic [7:0] OUT_PORT,
    input  logic       LOAD,
    output logic       TX,
    output logic       TXRDY,
    output logic       TX_DONE
);

    localparam logic [CNT_W-1:0] OVR_DIV  = CNT_W'(DIV_OVERRIDE);
    localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] shreg_d;
    logic [3:0]            idx_q;
    logic [3:0]            idx_d;
    logic [CNT_W-1:0]      div_q;
    logic [CNT_W-1:0]      div_d;
    logic                  done_q;
    logic                  done_d;
    logic                  bit_done;

    // Frame bit i is transmitted in bit-time i; unused tail positions are stop-level 1s.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data, input logic eight,
                                                         input logic pen, input logic odd);
        logic                  p;
        logic [FRAME_BITS-1:0] f;
        p      = parity_bit(data, eight, odd);
        f      = '1;
        f[0]   = 1'b0;
        f[7:1] = data[6:0];
        if (eight) begin
            f[8] = data[7];
            if (pen) f[9] = p;
        end else if (pen) begin
            f[8] = p;
        end
        return f;
    endfunction

    uart_baud_tick u_tick (
        .clk      (CLK),
        .rst_n    (RESET),
        .en       (state_q == ST_SHIFT),
        .div      (div_q),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        div_d   = div_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (LOAD) begin
                    state_d = ST_SHIFT;
                    shreg_d = build_frame(OUT_PORT, EIGHT, PEN, OHEL);
                    div_d   = (DIV_OVERRIDE != 0) ? OVR_DIV : baud_div(BAUD, CLK_HZ);
                    idx_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (bit_done) begin
                    shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Idle shift register is all ones, so TX rests high without extra muxing.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            shreg_q <= '1;
            idx_q   <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    assign TX      = shreg_q[0];
    assign TXRDY   = (state_q == ST_IDLE);
    assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine with a 16-clock bit time: table vectors, random frames
// against a bit-list model, and hand sequences for the multi-cycle corner cases.
module tb_uart_tx_engine;

    localparam int DIV = 16;
    localparam int FRAME_CYC = 11 * DIV;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] BAUD = 4'd8;
    logic       EIGHT = 1'b1;
    logic       PEN = 1'b0;
    logic       OHEL = 1'b0;
    logic [7:0] OUT_PORT = 8'h00;
    logic       LOAD = 1'b0;
    logic       TX;
    logic       TXRDY;
    logic       TX_DONE;

    int n_pass = 0;
    int n_total = 0;

    uart_tx_engine #(.CLK_HZ(100000000), .DIV_OVERRIDE(DIV)) dut (
        .CLK(CLK), .RESET(RESET), .BAUD(BAUD), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
        .OUT_PORT(OUT_PORT), .LOAD(LOAD), .TX(TX), .TXRDY(TXRDY), .TX_DONE(TX_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    typedef struct {
        string      name;
        logic [7:0] d;
        logic       e;
        logic       p;
        logic       o;
        logic [10:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Line-level model: start bit, data bits LSB first, optional parity, then 1s to 11 bits.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e, input logic p, input logic o);
        logic [10:0] f;
        int n, pos, ones;
        f = '1;
        f[0] = 1'b0;
        n = e ? 8 : 7;
        pos = 1;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            f[pos] = d[i];
            if (d[i]) ones++;
            pos++;
        end
        if (p) f[pos] = (ones % 2 == 1) ? ~o : o;
        return f;
    endfunction

    task automatic start_load(input logic [7:0] d, input logic e, input logic p, input logic o);
        OUT_PORT = d; EIGHT = e; PEN = p; OHEL = o; LOAD = 1'b1;
        @(posedge CLK);
        #1 LOAD = 1'b0;
    endtask

    // Called just after the accepting edge; returns at the sample where TXRDY should be back.
    task automatic frame_check(input string name, input logic [10:0] exp, input bit disturb, output int low_cnt);
        logic [10:0] obs;
        bit stable;
        int dones;
        obs = '0; stable = 1'b1; dones = 0; low_cnt = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge CLK);
            if (k % DIV == DIV / 2) obs[k / DIV] = TX;
            if (TX !== exp[k / DIV]) stable = 1'b0;
            if (TXRDY === 1'b0) low_cnt++;
            if (TX_DONE !== 1'b0) dones++;
            if (disturb && k == 40) begin
                LOAD = 1'b1; OUT_PORT = 8'h3C; EIGHT = ~EIGHT; PEN = ~PEN;
            end
            if (disturb && k == 41) LOAD = 1'b0;
        end
        chk({name, " bits"}, 32'(obs), 32'(exp));
        chk({name, " bit-hold"}, 32'(stable), 32'd1);
        chk({name, " early-done"}, dones, 0);
        chk({name, " txrdy-low"}, low_cnt, FRAME_CYC);
        @(negedge CLK);
        chk({name, " end tx/rdy/done"}, {29'd0, TX, TXRDY, TX_DONE}, 32'b111);
    endtask

    task automatic idle_check(input string name, input int n);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            if ({TX, TXRDY, TX_DONE} !== 3'b110) bad++;
        end
        chk({name, " idle"}, bad, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int low1, low2, dones;
        logic [7:0] d;
        logic e, p, o;

        vecs[0] = '{"8N A5", 8'hA5, 1'b1, 1'b0, 1'b0, 11'b11101001010};
        vecs[1] = '{"8E 07", 8'h07, 1'b1, 1'b1, 1'b0, 11'b11000001110};
        vecs[2] = '{"8O 07", 8'h07, 1'b1, 1'b1, 1'b1, 11'b10000001110};
        vecs[3] = '{"7E FF", 8'hFF, 1'b0, 1'b1, 1'b0, 11'b11111111110};
        vecs[4] = '{"7O 00", 8'h00, 1'b0, 1'b1, 1'b1, 11'b11100000000};
        vecs[5] = '{"7N 80", 8'h80, 1'b0, 1'b0, 1'b0, 11'b11100000000};

        repeat (3) @(negedge CLK);
        chk("in reset", {29'd0, TX, TXRDY, TX_DONE}, 32'b110);
        RESET = 1'b1;
        idle_check("after reset", 100);

        for (int i = 0; i < 6; i++) begin
            start_load(vecs[i].d, vecs[i].e, vecs[i].p, vecs[i].o);
            frame_check(vecs[i].name, vecs[i].exp, 1'b0, low1);
            @(negedge CLK);
            chk({vecs[i].name, " done pulse width"}, 32'(TX_DONE), 32'd0);
        end

        // LOAD and format changes during a frame must not alter or repeat it
        start_load(8'hA5, 1'b1, 1'b0, 1'b0);
        frame_check("ignored load", 11'b11101001010, 1'b1, low1);
        EIGHT = 1'b1; PEN = 1'b0;
        idle_check("no second frame", 200);

        // Back-to-back: LOAD presented in the first cycle TXRDY reads 1
        start_load(8'hA5, 1'b1, 1'b0, 1'b0);
        frame_check("b2b first", 11'b11101001010, 1'b0, low1);
        start_load(8'h55, 1'b1, 1'b0, 1'b0);
        frame_check("b2b second", {2'b11, 8'h55, 1'b0}, 1'b0, low2);
        chk("b2b total low", low1 + low2, 2 * FRAME_CYC);
        idle_check("after b2b", 20);

        // Reset in the middle of bit 5 (D4 = 0 for 0x0F)
        start_load(8'h0F, 1'b1, 1'b0, 1'b0);
        repeat (5 * DIV + 4) @(negedge CLK);
        chk("pre-reset tx", 32'(TX), 32'd0);
        #2 RESET = 1'b0;
        #1 chk("async abort", {29'd0, TX, TXRDY, TX_DONE}, 32'b110);
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (TX_DONE !== 1'b0) dones++;
        end
        chk("no done in reset", dones, 0);
        RESET = 1'b1;
        idle_check("after abort", 200);
        start_load(8'hC3, 1'b0, 1'b1, 1'b1);
        frame_check("post-reset 7O C3", model_frame(8'hC3, 1'b0, 1'b1, 1'b1), 1'b0, low1);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            e = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            @(negedge CLK);
            start_load(d, e, p, o);
            frame_check($sformatf("rand%0d %0h e%0d p%0d o%0d", i, d, e, p, o),
                        model_frame(d, e, p, o), 1'b0, low1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
